// File: rtl/noc_pkg.sv
// Shared constants, FSM encoding and packet helpers for the 4-PE NoC.
package noc_pkg;

  localparam int N_PORTS  = 4;
  localparam int DATA_W   = 8;
  localparam int ID_W     = 2;
  localparam int DEST_LSB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } sched_state_e;

  function automatic logic [ID_W-1:0] dest_of(input logic [DATA_W-1:0] pkt);
    return pkt[DEST_LSB +: ID_W];
  endfunction

  function automatic logic [ID_W-1:0] next_port(input logic [ID_W-1:0] p);
    return (p == ID_W'(N_PORTS - 1)) ? '0 : p + ID_W'(1);
  endfunction

endpackage

// File: rtl/noc_rr_scheduler_rr_pick.sv
// Combinational N-way round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

  logic [ID_W:0] slot;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr_i} + (ID_W + 1)'(k);
      if (slot >= N_W) slot = slot - N_W;
      if (!any_o && req_i[slot[ID_W-1:0]]) begin
        any_o                    = 1'b1;
        idx_o                    = slot[ID_W-1:0];
        gnt_o[slot[ID_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_rr_scheduler.sv
// Round-robin FIFO-to-FIFO transfer scheduler: pop one eligible head, push it to its
// destination FIFO, drop loopback packets. All strobes and status outputs are registered.
//
// state | meaning
// IDLE  | searching for an eligible source starting at rr_ptr
// POP   | pop the granted source and capture its head packet
// PUSH  | hold the packet until the destination FIFO has room, then push it
module noc_rr_scheduler
  import noc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        fifo_empty,
  input  logic [N_PORTS-1:0]        fifo_full,
  input  logic [N_PORTS*DATA_W-1:0] fifo_head_flat,
  output logic [N_PORTS-1:0]        fifo_rd_en,
  output logic [N_PORTS-1:0]        fifo_wr_en,
  output logic [DATA_W-1:0]         xfer_data,
  output logic [ID_W-1:0]           src,
  output logic [ID_W-1:0]           dest,
  output logic                      valid,
  output logic                      busy,
  output logic [CNT_W-1:0]          xfer_cnt,
  output logic [CNT_W-1:0]          drop_cnt
);

  sched_state_e state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    g_q, g_d;
  logic [ID_W-1:0]    d_q, d_d;
  logic               loop_q, loop_d;
  logic [DATA_W-1:0]  pkt_q, pkt_d;
  logic [N_PORTS-1:0] rd_en_q, rd_en_d;
  logic [N_PORTS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  xdata_q, xdata_d;
  logic [ID_W-1:0]    src_q, src_d;
  logic [ID_W-1:0]    dest_q, dest_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [DATA_W-1:0]  head      [N_PORTS];
  logic [ID_W-1:0]    head_dest [N_PORTS];
  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [ID_W-1:0]    pick_dest;

  // A port whose pop strobe is on the wire still shows its old head; keep it out of the search.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      head[i]      = fifo_head_flat[i*DATA_W +: DATA_W];
      head_dest[i] = dest_of(head[i]);
      elig[i]      = !fifo_empty[i] && !rd_en_q[i] &&
                     ((head_dest[i] == ID_W'(i)) || !fifo_full[head_dest[i]]);
    end
  end

  rr_pick #(.N(N_PORTS), .ID_W(ID_W)) u_pick (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    pick_dest = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick_gnt[i]) pick_dest = head_dest[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    g_d        = g_q;
    d_d        = d_q;
    loop_d     = loop_q;
    pkt_d      = pkt_q;
    rd_en_d    = '0;
    wr_en_d    = '0;
    xdata_d    = xdata_q;
    src_d      = src_q;
    dest_d     = dest_q;
    valid_d    = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          g_d     = pick_idx;
          d_d     = pick_dest;
          loop_d  = (pick_dest == pick_idx);
          state_d = POP;
        end
      end
      POP: begin
        if (fifo_empty[g_q]) begin
          state_d = IDLE;
        end else begin
          rd_en_d = N_PORTS'(1) << g_q;
          pkt_d   = head[g_q];
          if (loop_q) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            rr_ptr_d   = next_port(g_q);
            state_d    = IDLE;
          end else begin
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        if (!fifo_full[d_q]) begin
          wr_en_d    = N_PORTS'(1) << d_q;
          xdata_d    = pkt_q;
          src_d      = g_q;
          dest_d     = d_q;
          valid_d    = 1'b1;
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
          rr_ptr_d   = next_port(g_q);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      g_q        <= '0;
      d_q        <= '0;
      loop_q     <= 1'b0;
      pkt_q      <= '0;
      rd_en_q    <= '0;
      wr_en_q    <= '0;
      xdata_q    <= '0;
      src_q      <= '0;
      dest_q     <= '0;
      valid_q    <= 1'b0;
      xfer_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      g_q        <= g_d;
      d_q        <= d_d;
      loop_q     <= loop_d;
      pkt_q      <= pkt_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      xdata_q    <= xdata_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      valid_q    <= valid_d;
      xfer_cnt_q <= xfer_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign fifo_wr_en = wr_en_q;
  assign xfer_data  = xdata_q;
  assign src        = src_q;
  assign dest       = dest_q;
  assign valid      = valid_q;
  assign busy       = (state_q != IDLE);
  assign xfer_cnt   = xfer_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_noc_rr_scheduler.sv
// Directed bench for noc_rr_scheduler: reset, round-robin order, vector table, stall/abort/reset corners.
module tb_noc_rr_scheduler;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fifo_empty, fifo_full, fifo_rd_en, fifo_wr_en;
  logic [31:0] fifo_head_flat;
  logic [7:0]  xfer_data;
  logic [1:0]  src, dest;
  logic        valid, busy;
  logic [15:0] xfer_cnt, drop_cnt;

  always #5 clk = ~clk;

  noc_rr_scheduler #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_head_flat (fifo_head_flat),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_wr_en     (fifo_wr_en),
    .xfer_data      (xfer_data),
    .src            (src),
    .dest           (dest),
    .valid          (valid),
    .busy           (busy),
    .xfer_cnt       (xfer_cnt),
    .drop_cnt       (drop_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [31:0] heads;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
    logic [7:0]  exp_data;
    logic [1:0]  exp_src;
    logic [1:0]  exp_dest;
    logic [1:0]  exp_ptr;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] e, input logic [3:0] f, input logic [31:0] h,
                              input logic [3:0] rd, input logic [3:0] wr, input logic [7:0] d,
                              input logic [1:0] s, input logic [1:0] ds, input logic [1:0] p);
    vec_t v;
    v.empty = e; v.full = f; v.heads = h; v.exp_rd = rd; v.exp_wr = wr;
    v.exp_data = d; v.exp_src = s; v.exp_dest = ds; v.exp_ptr = p;
    return v;
  endfunction

  vec_t vecs[10];
  int   exp_xfer, exp_drop;
  logic [7:0] last_data;
  logic [7:0] rr_heads [4];
  int   pushes;
  int   push_cyc [4];
  logic [1:0] push_src [4];
  logic [7:0] push_data [4];
  logic [3:0] push_wr [4];

  initial begin
    // heads are {p3, p2, p1, p0}; destination lives in bits [5:4]
    vecs[0] = mk(4'b1010, 4'b1000, {8'h00, 8'h19, 8'h00, 8'h35}, 4'b0100, 4'b0010, 8'h19, 2'd2, 2'd1, 2'd3);
    vecs[1] = mk(4'b1110, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h35}, 4'b0001, 4'b1000, 8'h35, 2'd0, 2'd3, 2'd1);
    vecs[2] = mk(4'b1101, 4'b0000, {8'h00, 8'h00, 8'h2A, 8'h00}, 4'b0010, 4'b0100, 8'h2A, 2'd1, 2'd2, 2'd2);
    vecs[3] = mk(4'b0111, 4'b1111, {8'hF5, 8'h00, 8'h00, 8'h00}, 4'b1000, 4'b0000, 8'h00, 2'd0, 2'd0, 2'd0);
    vecs[4] = mk(4'b0110, 4'b0000, {8'h1F, 8'h00, 8'h00, 8'h2C}, 4'b0001, 4'b0100, 8'h2C, 2'd0, 2'd2, 2'd1);
    vecs[5] = mk(4'b0110, 4'b0000, {8'h1F, 8'h00, 8'h00, 8'h2C}, 4'b1000, 4'b0010, 8'h1F, 2'd3, 2'd1, 2'd0);
    vecs[6] = mk(4'b0000, 4'b1000, {8'h0B, 8'h22, 8'h01, 8'h30}, 4'b0010, 4'b0001, 8'h01, 2'd1, 2'd0, 2'd2);
    vecs[7] = mk(4'b0000, 4'b1000, {8'h0B, 8'h22, 8'h01, 8'h30}, 4'b0100, 4'b0000, 8'h00, 2'd0, 2'd0, 2'd3);
    vecs[8] = mk(4'b0000, 4'b1000, {8'h0B, 8'h22, 8'h01, 8'h30}, 4'b1000, 4'b0001, 8'h0B, 2'd3, 2'd0, 2'd0);
    vecs[9] = mk(4'b0000, 4'b0001, {8'h0B, 8'h22, 8'h01, 8'h30}, 4'b0001, 4'b1000, 8'h30, 2'd0, 2'd3, 2'd1);

    rr_heads[0] = 8'h11; rr_heads[1] = 8'h22; rr_heads[2] = 8'h33; rr_heads[3] = 8'h04;

    // Reset with every FIFO holding a packet
    rst = 1'b1;
    fifo_empty = 4'b0000;
    fifo_full  = 4'b0000;
    fifo_head_flat = {rr_heads[3], rr_heads[2], rr_heads[1], rr_heads[0]};
    repeat (3) @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 4'b0);
    chk("rst_wr_en", fifo_wr_en, 4'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_xfer_cnt", xfer_cnt, 16'd0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    chk("rst_outs", {xfer_data, src, dest}, 12'h000);
    rst = 1'b0;

    // Round robin: all four ports, distinct non-self destinations
    pushes = 0;
    for (int k = 0; k < 4; k++) begin
      push_cyc[k] = 0; push_src[k] = '0; push_data[k] = '0; push_wr[k] = '0;
    end
    for (int c = 1; c <= 40 && pushes < 4; c++) begin
      @(negedge clk);
      if (fifo_wr_en != 4'b0) begin
        push_cyc[pushes]  = c;
        push_src[pushes]  = src;
        push_data[pushes] = xfer_data;
        push_wr[pushes]   = fifo_wr_en;
        pushes++;
      end
      fifo_empty = fifo_empty | fifo_rd_en;
    end
    chk("rr_push_count", pushes, 4);
    chk("rr_first_push_cycle", push_cyc[0], 3);
    for (int k = 0; k < 4; k++) begin
      chk("rr_src", push_src[k], k);
      chk("rr_data", push_data[k], rr_heads[k]);
      chk("rr_wr_en", push_wr[k], 4'b0001 << ((k + 1) % 4));
      if (k > 0) chk("rr_spacing", push_cyc[k] - push_cyc[k-1], 3);
    end
    fifo_empty = 4'b1111;
    exp_xfer  = 4;
    exp_drop  = 0;
    last_data = 8'h04;

    // Vector table: each record is one grant -> pop -> push/drop from IDLE
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      fifo_empty     = vecs[n].empty;
      fifo_full      = vecs[n].full;
      fifo_head_flat = vecs[n].heads;
      @(negedge clk);
      chk("vec_busy_pop", busy, 1'b1);
      chk("vec_rd_early", fifo_rd_en, 4'b0);
      @(negedge clk);
      chk("vec_rd_en", fifo_rd_en, vecs[n].exp_rd);
      fifo_empty = 4'b1111;
      @(negedge clk);
      chk("vec_wr_en", fifo_wr_en, vecs[n].exp_wr);
      chk("vec_valid", valid, vecs[n].exp_wr != 4'b0);
      if (vecs[n].exp_wr != 4'b0) begin
        chk("vec_data", xfer_data, vecs[n].exp_data);
        chk("vec_src_dest", {src, dest}, {vecs[n].exp_src, vecs[n].exp_dest});
        exp_xfer++;
        last_data = vecs[n].exp_data;
      end else begin
        chk("vec_hold_data", xfer_data, last_data);
        exp_drop++;
      end
      chk("vec_xfer_cnt", xfer_cnt, exp_xfer);
      chk("vec_drop_cnt", drop_cnt, exp_drop);
      chk("vec_rr_ptr", dut.rr_ptr_q, vecs[n].exp_ptr);
      fifo_full = 4'b0000;
    end

    // PUSH stall: destination fills during POP, head changes after pop
    @(negedge clk);
    fifo_empty = 4'b1101;
    fifo_head_flat = {8'h00, 8'h00, 8'h2A, 8'h00};
    @(negedge clk);
    fifo_full = 4'b0100;
    @(negedge clk);
    chk("stall_rd_en", fifo_rd_en, 4'b0010);
    fifo_empty = 4'b1111;
    fifo_head_flat = {8'h00, 8'h00, 8'h99, 8'h00};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_wr_low", fifo_wr_en, 4'b0);
      chk("stall_busy", busy, 1'b1);
    end
    fifo_full = 4'b0000;
    @(negedge clk);
    chk("stall_wr_en", fifo_wr_en, 4'b0100);
    chk("stall_data", xfer_data, 8'h2A);
    chk("stall_valid", valid, 1'b1);
    exp_xfer++;
    chk("stall_xfer_cnt", xfer_cnt, exp_xfer);
    @(negedge clk);
    chk("stall_single_push", {fifo_wr_en, valid}, 5'b0);

    // POP abort: granted source drains before the pop
    fifo_empty = 4'b1101;
    fifo_head_flat = {8'h00, 8'h00, 8'h2A, 8'h00};
    @(negedge clk);
    fifo_empty = 4'b1111;
    @(negedge clk);
    chk("abort_rd_en", fifo_rd_en, 4'b0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    chk("abort_strobes", {fifo_rd_en, fifo_wr_en}, 8'h00);
    chk("abort_rr_ptr", dut.rr_ptr_q, 2'd2);
    chk("abort_xfer_cnt", xfer_cnt, exp_xfer);

    // Reset while stalled in PUSH
    fifo_empty = 4'b1101;
    @(negedge clk);
    fifo_full = 4'b0100;
    @(negedge clk);
    chk("rstpush_rd_en", fifo_rd_en, 4'b0010);
    chk("rstpush_busy", busy, 1'b1);
    fifo_empty = 4'b1111;
    fifo_full  = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    chk("rstpush_wr_in_rst", fifo_wr_en, 4'b0);
    chk("rstpush_busy_off", busy, 1'b0);
    chk("rstpush_cnt", {xfer_cnt, drop_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstpush_wr_after", {fifo_wr_en, fifo_rd_en, valid}, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
